// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns: COLS_PER_CYCLE columns per busy cycle.
// Define AES_MIX_COLUMNS_INV_EN to build the inverse datapath and honour in_inv.
module aes_mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned NumSteps = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LastStep = 2'(NumSteps - 1);
    localparam int Cpc = int'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] buf_q, buf_d;
    logic [127:0] out_q, out_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Byte lsb of column (step * Cpc + k) within the 128-bit state.
    function automatic int col_lsb(input logic [1:0] step, input int k);
        return 32 * (3 - (int'(step) * Cpc + k));
    endfunction

`ifdef AES_MIX_COLUMNS_INV_EN
    logic inv_q, inv_d;

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0]       a, x2, x4, x8;
        logic [3:0][7:0]  m9, mb, md, me;
        for (int i = 0; i < 4; i++) begin
            a     = c[8*(3-i) +: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        buf_d     = buf_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef AES_MIX_COLUMNS_INV_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StBusy: begin
                for (int k = 0; k < Cpc; k++) begin
`ifdef AES_MIX_COLUMNS_INV_EN
                    out_d[col_lsb(col_q, k) +: 32] = inv_q ? inv_col(buf_q[col_lsb(col_q, k) +: 32])
                                                           : fwd_col(buf_q[col_lsb(col_q, k) +: 32]);
`else
                    out_d[col_lsb(col_q, k) +: 32] = fwd_col(buf_q[col_lsb(col_q, k) +: 32]);
`endif
                end
                if (col_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new accept overrides the DONE->IDLE return (zero-bubble restart).
        if (in_valid && in_ready) begin
            state_d = StBusy;
            col_d   = 2'd0;
            buf_d   = in_state;
`ifdef AES_MIX_COLUMNS_INV_EN
            inv_d   = in_inv;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            buf_q   <= '0;
            out_q   <= '0;
`ifdef AES_MIX_COLUMNS_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
`ifdef AES_MIX_COLUMNS_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign out_state = out_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Bench for aes_mix_columns_iter: three instances (1, 2 and 4 columns per cycle) share stimulus.
module tb_aes_mix_columns_iter;

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] Garbage = 128'h0123456789abcdeffedcba9876543210;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_ready;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] os [3];

    int           n_cmp;
    int           n_bad;
    logic [127:0] last_exp;
    vec_t         tbl [9];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_state (in_state),
            .in_inv   (in_inv),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_state(os[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge; ends at the negedge 4 edges after the accept edge.
    task automatic txn(input vec_t v, input bit b2b, input string tag);
        logic [127:0] mask;
        in_state  = v.st;
        in_inv    = v.inv;
        in_valid  = 1'b1;
        out_ready = b2b;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("%s.d%0d.acc_rdy", tag, d), 128'(ir[d]), 128'd1);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s.d%0d.k%0d.ov", tag, d, k), 128'(ov[d]), 128'(k >= (4 >> d)));
                chk($sformatf("%s.d%0d.k%0d.rdy", tag, d, k), 128'(ir[d]), 128'd0);
                if (k >= (4 >> d)) begin
                    chk($sformatf("%s.d%0d.k%0d.os", tag, d, k), os[d], v.exp);
                end else begin
                    mask = ~128'd0 >> (32 * k * (1 << d));
                    chk($sformatf("%s.d%0d.k%0d.part", tag, d, k), os[d],
                        (v.exp & ~mask) | (last_exp & mask));
                end
            end
            if (k < 4) begin
                in_valid = 1'b1;
                in_state = Garbage;
                in_inv   = ~v.inv;
            end else begin
                in_valid = 1'b0;
            end
        end
        last_exp = v.exp;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.d%0d.drain_ov", tag, d), 128'(ov[d]), 128'd0);
            chk($sformatf("%s.d%0d.drain_rdy", tag, d), 128'(ir[d]), 128'd1);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        last_exp  = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{st: 128'hd4bf5d30e0b452aeb84111f11e2798e5, inv: 1'b0,
                   exp: 128'h046681e5e0cb199a48f8d37a2806264c};
        tbl[1] = '{st: {4{32'hdb135345}}, inv: 1'b0, exp: {4{32'h8e4da1bc}}};
        tbl[2] = '{st: {4{32'h01010101}}, inv: 1'b0, exp: {4{32'h01010101}}};
        tbl[3] = '{st: {4{32'hc6c6c6c6}}, inv: 1'b0, exp: {4{32'hc6c6c6c6}}};
        tbl[4] = '{st: {4{32'hd4d4d4d5}}, inv: 1'b0, exp: {4{32'hd5d5d7d6}}};
        tbl[5] = '{st: {32'hdb135345, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, inv: 1'b0,
                   exp: {32'h8e4da1bc, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}};
        tbl[6] = '{st: {32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6}, inv: 1'b1,
                   exp: {32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6}};
`ifdef AES_MIX_COLUMNS_INV_EN
        tbl[7] = '{st: {4{32'h8e4da1bc}}, inv: 1'b1, exp: {4{32'hdb135345}}};
        tbl[8] = '{st: 128'h046681e5e0cb199a48f8d37a2806264c, inv: 1'b1,
                   exp: 128'hd4bf5d30e0b452aeb84111f11e2798e5};
`else
        tbl[7] = '{st: {4{32'h8e4da1bc}}, inv: 1'b1, exp: {4{32'hcd504506}}};
        tbl[8] = '{st: 128'hd4bf5d30e0b452aeb84111f11e2798e5, inv: 1'b1,
                   exp: 128'h046681e5e0cb199a48f8d37a2806264c};
`endif

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.d%0d.ov", d), 128'(ov[d]), 128'd0);
            chk($sformatf("rst.d%0d.rdy", d), 128'(ir[d]), 128'd1);
            chk($sformatf("rst.d%0d.os", d), os[d], 128'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            txn(tbl[i], 1'b0, $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Stall in DONE, then hand-off with a simultaneous new accept.
        txn(tbl[0], 1'b0, "stall");
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("stall.d%0d.ov", d), 128'(ov[d]), 128'd1);
                chk($sformatf("stall.d%0d.rdy", d), 128'(ir[d]), 128'd0);
                chk($sformatf("stall.d%0d.os", d), os[d], tbl[0].exp);
            end
        end
        txn(tbl[1], 1'b1, "b2b");
        drain("b2b");

        // Reset pulse in the second busy cycle.
        in_state = tbl[4].st;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst.d%0d.ov", d), 128'(ov[d]), 128'd0);
            chk($sformatf("midrst.d%0d.os", d), os[d], 128'd0);
            chk($sformatf("midrst.d%0d.rdy", d), 128'(ir[d]), 128'd1);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        last_exp = '0;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk($sformatf("postrst.d%0d.ov", d), 128'(ov[d]), 128'd0);
        end
        txn(tbl[5], 1'b0, "recover");
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_iter.md
AES_MIX_COLUMNS_ITER -- requirements
Module: aes_mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per busy cycle; legal values 1, 2, 4.
REQ-002 SHALL have ports clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  input state offered.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_state  input  128  AES state; column c = bits [127-32c -: 32], row-0 byte in column bits [31:24].
REQ-007 SHALL have port in_inv  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_state  output  128  transformed state, same byte layout as in_state.
REQ-011 SHALL use one clock; reset asynchronous and active-low.

Function
REQ-012 SHALL run FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 SHALL assert in_ready in IDLE, and in DONE when out_ready=1; deasserted in BUSY.
REQ-014 SHALL accept on in_valid & in_ready: capture in_state, latch in_inv, clear column counter, enter BUSY.
REQ-015 SHALL, in BUSY, transform COLS_PER_CYCLE columns per cycle, lowest column index first, writing results into out_state holding register.
REQ-016 SHALL stay in BUSY exactly 4/COLS_PER_CYCLE cycles; out_valid rises the cycle after the last column; accept-to-out_valid latency = 4/COLS_PER_CYCLE cycles.
REQ-017 Forward column (a0..a3 -> b0..b3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, GF(2^8) mod 0x11B.
REQ-018 Inverse column: coefficient rows {0e,0b,0d,09} rotated right by one per output row, GF(2^8) mod 0x11B.
REQ-019 SHALL hold out_valid and out_state stable in DONE until out_valid & out_ready.
REQ-020 On handshake in DONE with no new input: return to IDLE, out_valid=0 next cycle.
REQ-021 On handshake in DONE with simultaneous in_valid: accept new state, enter BUSY directly (zero bubble); out_state retains old value until overwritten column-by-column.
REQ-022 SHALL ignore in_valid, in_state, in_inv changes while BUSY; latched mode governs whole transaction.
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 Illegal COLS_PER_CYCLE SHALL produce an elaboration-time error.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, out_valid=0, out_state=0, column counter=0, latched mode=0; in_ready=1 once in IDLE.
REQ-026 Reset mid-BUSY or in DONE SHALL discard the transaction; no out_valid after release until a new accept.
REQ-027 First accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-028 Macro AES_MIX_COLUMNS_INV_EN defined: inverse datapath present, in_inv honoured.
REQ-029 Macro undefined: inverse datapath absent, in_inv ignored, all transactions forward; port list unchanged.

Verification
REQ-030 COLS_PER_CYCLE=1, in_inv=0, in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=046681e5e0cb199a48f8d37a2806264c, out_valid 4 cycles after accept.
REQ-031 COLS_PER_CYCLE=4, column db135345 (all four columns), in_inv=0 -> each column 8e4da1bc, latency 1 cycle.
REQ-032 AES_MIX_COLUMNS_INV_EN, in_inv=1, in_state=046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; macro undefined, same stimulus -> forward result.
REQ-033 COLS_PER_CYCLE=2, out_ready held 0 for 5 cycles -> out_valid/out_state stable, in_ready=0; out_ready=1 with in_valid=1 -> new accept same cycle, next out_valid 2 cycles later.
REQ-034 rst_n pulsed low during BUSY cycle 2 -> out_valid=0, out_state=0 immediately; no spurious output after release.
REQ-035 Columns 01010101 and c6c6c6c6 -> unchanged in both modes; d4d4d4d5 forward -> d5d5d7d6.
